alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle-flagged ALU: same 4-bit function encoding (2-bit class + 2-bit op), generalised DATA_WIDTH.
- Adds a valid/ready handshake on both sides with full backpressure, a fixed 2-cycle pipeline, variable shift amounts, and carry and divide-by-zero status.
- Sits between the register-file/controller datapath and the result write-back path of the system.

---
 rtl/alu_pipe.sv | 145 ++++++++++++++
 tb/tb_alu_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 captures operands, S2 holds the computed result and flags.
// Enable low freezes every register and masks both handshake outputs.
module alu_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Enable,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [3:0]            ALU_FUN,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [OUT_WIDTH-1:0]  ALU_OUT,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  CARRY,
    output logic                  DIV_ERR
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    logic                  s1_valid;
    logic                  s2_valid;
    logic [3:0]            s1_fun;
    logic [DATA_WIDTH-1:0] s1_a;
    logic [DATA_WIDTH-1:0] s1_b;

    logic s2_free;
    logic s1_adv;
    logic accept;
    logic pop;

    assign s2_free   = !s2_valid || OUT_READY;
    assign s1_adv    = s1_valid && s2_free && Enable;
    assign IN_READY  = Enable && (!s1_valid || s2_free);
    assign accept    = IN_VALID && IN_READY;
    assign pop       = s2_valid && OUT_READY;
    assign OUT_VALID = s2_valid && Enable;

    // Narrow intermediates are zero-extended only after the op, so NAND/NOR never set upper bits.
    logic [SHAMT_W-1:0]    sh;
    logic [SHAMT_W:0]      rot_r;
    logic [DATA_WIDTH:0]   add_w;
    logic [OUT_WIDTH-1:0]  ext_a;
    logic [OUT_WIDTH-1:0]  ext_b;
    logic [DATA_WIDTH-1:0] and_w;
    logic [DATA_WIDTH-1:0] or_w;
    logic [DATA_WIDTH-1:0] nand_w;
    logic [DATA_WIDTH-1:0] nor_w;
    logic [DATA_WIDTH-1:0] srl_w;
    logic [DATA_WIDTH-1:0] sll_w;
    logic [DATA_WIDTH-1:0] sra_w;
    logic [DATA_WIDTH-1:0] rol_w;

    assign sh     = s1_b[SHAMT_W-1:0];
    assign rot_r  = (SHAMT_W + 1)'(DATA_WIDTH) - {1'b0, sh};
    assign add_w  = {1'b0, s1_a} + {1'b0, s1_b};
    assign ext_a  = OUT_WIDTH'(s1_a);
    assign ext_b  = OUT_WIDTH'(s1_b);
    assign and_w  = s1_a & s1_b;
    assign or_w   = s1_a | s1_b;
    assign nand_w = ~(s1_a & s1_b);
    assign nor_w  = ~(s1_a | s1_b);
    assign srl_w  = s1_a >> sh;
    assign sll_w  = s1_a << sh;
    assign sra_w  = $signed(s1_a) >>> sh;
    assign rol_w  = (s1_a << sh) | (s1_a >> rot_r);

    logic [OUT_WIDTH-1:0] res;
    logic                 carry_n;
    logic                 div_err_n;

    always_comb begin
        res       = '0;
        carry_n   = 1'b0;
        div_err_n = 1'b0;
        case (s1_fun)
            4'b0000: begin
                res     = OUT_WIDTH'(add_w);
                carry_n = add_w[DATA_WIDTH];
            end
            4'b0001: begin
                res     = ext_a - ext_b;
                carry_n = (s1_a < s1_b);
            end
            4'b0010: res = ext_a * ext_b;
            4'b0011: begin
                if (s1_b == '0) begin
                    res       = '1;
                    div_err_n = 1'b1;
                end else begin
                    res = ext_a / ext_b;
                end
            end
            4'b0100: res = OUT_WIDTH'(and_w);
            4'b0101: res = OUT_WIDTH'(or_w);
            4'b0110: res = OUT_WIDTH'(nand_w);
            4'b0111: res = OUT_WIDTH'(nor_w);
            4'b1000: res = '0;
            4'b1001: res = (s1_a == s1_b) ? OUT_WIDTH'(1) : '0;
            4'b1010: res = (s1_a > s1_b)  ? OUT_WIDTH'(2) : '0;
            4'b1011: res = (s1_a < s1_b)  ? OUT_WIDTH'(3) : '0;
            4'b1100: res = OUT_WIDTH'(srl_w);
            4'b1101: res = OUT_WIDTH'(sll_w);
            4'b1110: res = OUT_WIDTH'(sra_w);
            4'b1111: res = OUT_WIDTH'(rol_w);
            default: res = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_fun   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            ALU_OUT  <= '0;
            CARRY    <= 1'b0;
            DIV_ERR  <= 1'b0;
        end else if (Enable) begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_fun   <= ALU_FUN;
                s1_a     <= A;
                s1_b     <= B;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            // A push into S2 wins over a pop, so pop+push in one edge keeps S2 full.
            if (s1_adv) begin
                s2_valid <= 1'b1;
                ALU_OUT  <= res;
                CARRY    <= carry_n;
                DIV_ERR  <= div_err_n;
            end else if (pop) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed and random traffic checked against an arithmetic reference
// model with an in-order expected-result queue and a two-slot occupancy tracker.
module tb_alu_pipe;

    localparam int DW = 8;
    localparam int OW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Enable = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [3:0]    ALU_FUN = 4'h0;
    logic [DW-1:0] A = '0;
    logic [DW-1:0] B = '0;
    logic [OW-1:0] ALU_OUT;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic          CARRY;
    logic          DIV_ERR;

    alu_pipe #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
        .CLK(CLK), .RST(RST), .Enable(Enable),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .ALU_FUN(ALU_FUN),
        .A(A), .B(B), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .CARRY(CARRY), .DIV_ERR(DIV_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic          e;
        logic          c;
        logic [OW-1:0] r;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   m_s1 = 1'b0;
    bit   m_s2 = 1'b0;

    function automatic exp_t ref_alu(logic [3:0] f, int a, int b);
        int   mask = (1 << DW) - 1;
        int   sh = b % DW;
        int   r = 0;
        int   sa;
        exp_t o;
        o.c = 1'b0;
        o.e = 1'b0;
        case (f)
            4'h0: begin r = a + b; o.c = (a + b) > mask; end
            4'h1: begin r = (a - b) & ((1 << OW) - 1); o.c = (a < b); end
            4'h2: r = a * b;
            4'h3: begin
                if (b == 0) begin r = (1 << OW) - 1; o.e = 1'b1; end
                else r = a / b;
            end
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = (~(a & b)) & mask;
            4'h7: r = (~(a | b)) & mask;
            4'h8: r = 0;
            4'h9: r = (a == b) ? 1 : 0;
            4'hA: r = (a > b) ? 2 : 0;
            4'hB: r = (a < b) ? 3 : 0;
            4'hC: r = a >> sh;
            4'hD: r = (a << sh) & mask;
            4'hE: begin
                sa = (a >= (1 << (DW - 1))) ? a - (1 << DW) : a;
                r  = (sa >>> sh) & mask;
            end
            default: r = ((a << sh) | (a >> (DW - sh))) & mask;
        endcase
        o.r = r[OW-1:0];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive after the falling edge, check, advance the model, wait for next falling edge.
    task automatic cycle(input bit iv, input logic [3:0] f, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input bit ordy, input bit en);
        bit exp_rdy, pop, adv, acc;
        exp_t head;
        IN_VALID  = iv;
        ALU_FUN   = f;
        A         = a;
        B         = b;
        OUT_READY = ordy;
        Enable    = en;
        #1;
        exp_rdy = en && (!m_s1 || !m_s2 || ordy);
        chk("in_ready", 32'(IN_READY), 32'(exp_rdy));
        chk("out_valid", 32'(OUT_VALID), 32'(m_s2 && en));
        if (m_s2) begin
            head = exp_q[0];
            chk("alu_out", 32'(ALU_OUT), 32'(head.r));
            chk("carry", 32'(CARRY), 32'(head.c));
            chk("div_err", 32'(DIV_ERR), 32'(head.e));
        end
        if (en) begin
            pop = m_s2 && ordy;
            adv = m_s1 && (!m_s2 || ordy);
            acc = iv && exp_rdy;
            if (pop) void'(exp_q.pop_front());
            m_s2 = adv || (m_s2 && !pop);
            m_s1 = acc || (m_s1 && !adv);
            if (acc) exp_q.push_back(ref_alu(f, int'(a), int'(b)));
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1);
    endtask

    initial begin
        @(negedge CLK);
        chk("rst_alu_out", 32'(ALU_OUT), 32'h0);
        chk("rst_out_valid", 32'(OUT_VALID), 32'h0);
        chk("rst_carry", 32'(CARRY), 32'h0);
        chk("rst_div_err", 32'(DIV_ERR), 32'h0);
        RST = 1'b1;

        // Arithmetic back to back
        cycle(1'b1, 4'h0, 8'hFF, 8'h01, 1'b1, 1'b1);
        cycle(1'b1, 4'h1, 8'h03, 8'h05, 1'b1, 1'b1);
        cycle(1'b1, 4'h2, 8'hFF, 8'hFF, 1'b1, 1'b1);
        cycle(1'b1, 4'h3, 8'h07, 8'h00, 1'b1, 1'b1);
        // Shifts, rotate by zero, compares, NAND
        cycle(1'b1, 4'hC, 8'h81, 8'h03, 1'b1, 1'b1);
        cycle(1'b1, 4'hD, 8'h81, 8'h03, 1'b1, 1'b1);
        cycle(1'b1, 4'hE, 8'h81, 8'h03, 1'b1, 1'b1);
        cycle(1'b1, 4'hF, 8'h81, 8'h03, 1'b1, 1'b1);
        cycle(1'b1, 4'hF, 8'h81, 8'h08, 1'b1, 1'b1);
        cycle(1'b1, 4'h9, 8'h05, 8'h05, 1'b1, 1'b1);
        cycle(1'b1, 4'hA, 8'h09, 8'h04, 1'b1, 1'b1);
        cycle(1'b1, 4'hB, 8'h09, 8'h04, 1'b1, 1'b1);
        cycle(1'b1, 4'h6, 8'hF0, 8'h3C, 1'b1, 1'b1);
        idle(3);

        // Backpressure: two accepts fill the pipe, third op waits for release
        cycle(1'b1, 4'h0, 8'h10, 8'h20, 1'b0, 1'b1);
        cycle(1'b1, 4'h2, 8'h03, 8'h04, 1'b0, 1'b1);
        cycle(1'b1, 4'h5, 8'h0A, 8'h50, 1'b0, 1'b1);
        cycle(1'b1, 4'h5, 8'h0A, 8'h50, 1'b0, 1'b1);
        cycle(1'b1, 4'h5, 8'h0A, 8'h50, 1'b1, 1'b1);
        idle(3);

        // Enable low with both stages full
        cycle(1'b1, 4'h1, 8'h40, 8'h01, 1'b0, 1'b1);
        cycle(1'b1, 4'h3, 8'hC8, 8'h07, 1'b0, 1'b1);
        cycle(1'b1, 4'h0, 8'h11, 8'h22, 1'b1, 1'b0);
        cycle(1'b1, 4'h0, 8'h11, 8'h22, 1'b1, 1'b0);
        cycle(1'b1, 4'h0, 8'h11, 8'h22, 1'b1, 1'b0);
        idle(3);

        // Reset mid-stream with valids high
        cycle(1'b1, 4'h2, 8'h9A, 8'h77, 1'b1, 1'b1);
        cycle(1'b1, 4'h0, 8'hF1, 8'h3F, 1'b1, 1'b1);
        cycle(1'b1, 4'h1, 8'h01, 8'hF0, 1'b1, 1'b1);
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        #2 RST = 1'b0;
        #1;
        chk("midrst_alu_out", 32'(ALU_OUT), 32'h0);
        chk("midrst_out_valid", 32'(OUT_VALID), 32'h0);
        chk("midrst_carry", 32'(CARRY), 32'h0);
        chk("midrst_div_err", 32'(DIV_ERR), 32'h0);
        exp_q.delete();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        idle(2);
        cycle(1'b1, 4'h0, 8'h12, 8'h34, 1'b0, 1'b1);
        idle(3);

        // Random traffic with stalls, enable drops and frequent zero divisors
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), ra, rb,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
